uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BR, default 0, meaning line baud rate in bit/s.
REQ-002 SHALL have parameter CLKF, default 0, meaning clk frequency in Hz.
REQ-003 SHALL have parameter OVS, default 16, meaning oversampling ticks per bit.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 SHALL have port data  output  8  received byte, valid while valid=1.
REQ-008 SHALL have port valid  output  1  byte available, held until accepted.
REQ-009 SHALL have port ready  input  1  consumer accepts data when valid&ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on stop bit sampled 0.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse on frame completed while valid=1.

Function
REQ-012 SHALL elaborate-time $fatal if BR=0, CLKF=0, OVS<4, or CLKF/(BR*OVS) is not a whole number >=1; TICK_DIV = CLKF/(BR*OVS).
REQ-013 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-014 SHALL generate a one-clk tick every TICK_DIV clks; the tick counter is cleared on start-edge detection, so ticks are phase-aligned to each frame.
REQ-015 SHALL implement FSM IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-016 IDLE: synchronized 1->0 transition -> START, clear tick and tick-count counters.
REQ-017 START: after OVS/2 ticks, sample; 0 -> DATA; 1 -> IDLE as false start, no outputs change.
REQ-018 DATA: sample every OVS ticks, 8 bits, LSB first, into a shift register; after bit 7 -> STOP.
REQ-019 STOP: sample after OVS ticks; 1 and valid=0 -> load data, set valid next clk, -> IDLE.
REQ-020 STOP sampled 1 with valid=1 -> pulse overrun, discard new byte, keep data and valid unchanged, -> IDLE.
REQ-021 STOP sampled 0 -> pulse frame_err, discard byte, wait for synchronized rx=1 (break), then -> IDLE.
REQ-022 valid SHALL clear on the clk after valid&ready; a same-cycle new load takes priority and valid stays 1 with the new data.
REQ-023 data SHALL be stable for as long as valid=1.
REQ-024 Latency: valid SHALL rise no later than 3 clks after the mid-stop-bit sample tick.

Reset
REQ-025 reset SHALL force IDLE, all counters 0, shift register 0, data=0, valid=0, frame_err=0, overrun=0, synchronizer=1.
REQ-026 reset asserted mid-frame SHALL abandon the frame; after release, the next falling edge starts a fresh frame.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, PARITY state SHALL sit between DATA and STOP and sample one even-parity bit after OVS ticks; mismatch SHALL pulse output parity_err (1 bit) and discard the byte.
REQ-028 Without UART_RX_PARITY_EN, PARITY state and parity_err SHALL NOT exist; frame is 8N1.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state enum typedef, DATA_BITS=8, and the even-parity function.
REQ-030 Tick generation SHALL be a sub-module uart_rx_tick (clk, reset, clear, tick), holding the REQ-012 checks.

Verification (BR=115200, CLKF=18432000, OVS=16 -> TICK_DIV=10, 160 clk/bit)
REQ-031 Frame 0xA5 8N1, ready=1 -> valid pulses once with data=0xA5 within 1524 clks of the start edge; no error pulses.
REQ-032 rx low for 50 clks, then high -> no valid, no frame_err; FSM returns to IDLE.
REQ-033 Frame 0x3C with stop bit 0 for 1 bit, then high -> frame_err one pulse, valid stays 0.
REQ-034 Frames 0x11 then 0x22, ready=0 -> data=0x11, valid=1, one overrun pulse; ready=1 for 1 clk -> valid=0.
REQ-035 reset asserted during bit 3 of 0x55, released, then frame 0x0F -> only data=0x0F delivered.
REQ-036 UART_RX_PARITY_EN defined, 0x07 with parity bit 0 -> parity_err pulse, valid stays 0; parity bit 1 -> data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver slice.
//   uart_state_t : receiver FSM state encoding
//   DATA_BITS    : payload bits per frame (8)
//   even_parity  : parity bit that makes the total count of ones even
// Optional feature macro: UART_RX_PARITY_EN adds the ST_PARITY state.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_t;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if -- consumer-side bundle of the UART receiver.
//   data       : received byte, stable while valid=1
//   valid      : byte available, held until accepted
//   ready      : consumer accepts the byte when valid & ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, frame completed while valid=1
//   parity_err : one-cycle pulse, parity mismatch (only with UART_RX_PARITY_EN)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;

  logic [uart_pkg::DATA_BITS-1:0] data;
  logic                           valid;
  logic                           ready;
  logic                           frame_err;
  logic                           overrun;

`ifdef UART_RX_PARITY_EN
  logic                           parity_err;

  modport master (output data, valid, frame_err, overrun, parity_err, input ready);
  modport slave  (input  data, valid, frame_err, overrun, parity_err, output ready);
`else
  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input  data, valid, frame_err, overrun, output ready);
`endif

endinterface

// File: rtl/uart_rx_tick.sv
// uart_rx_tick -- oversampling tick generator for uart_rx.
// Produces a one-clk tick every TICK_DIV = CLKF/(BR*OVS) clocks. Asserting
// clear restarts the divider so the tick phase is aligned to a new frame.
// Invalid parameter combinations stop elaboration.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   clear : restart the divider (counter back to 0)
//   tick  : one-clk oversampling tick
module uart_rx_tick #(
  parameter int BR   = 0,
  parameter int CLKF = 0,
  parameter int OVS  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // Guarded so a zero baud rate cannot cause a divide by zero before the
  // configuration check below reports it.
  localparam int BAUD_TICKS = BR * OVS;
  localparam int TICK_DIV   = (BAUD_TICKS > 0) ? (CLKF / BAUD_TICKS) : 0;
  localparam int TICK_REM   = (BAUD_TICKS > 0) ? (CLKF % BAUD_TICKS) : 1;
  localparam int CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TICK_DIV > 0) ? (TICK_DIV - 1) : 0);

  if (BR <= 0 || CLKF <= 0 || OVS < 4) begin : g_bad_cfg
    $fatal(1, "uart_rx_tick: BR and CLKF must be nonzero and OVS must be >= 4");
  end else if (TICK_DIV < 1 || TICK_REM != 0) begin : g_bad_div
    $fatal(1, "uart_rx_tick: CLKF/(BR*OVS) must be a whole number >= 1");
  end

  logic [CW-1:0] cnt;

  // Free-running divider; wraps on the tick and restarts on clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with oversampled mid-bit sampling.
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-high; abandons any frame in progress
//   rx    : serial line, asynchronous to clk, idle high
//   bus   : uart_rx_if.master (data, valid, ready, frame_err, overrun
//           and, with UART_RX_PARITY_EN, parity_err)
// Parameters: BR (baud rate), CLKF (clk frequency in Hz), OVS (ticks per bit).
// Optional feature macro: UART_RX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_rx
  import uart_pkg::*;
#(
  parameter int BR   = 0,
  parameter int CLKF = 0,
  parameter int OVS  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int TCW = (OVS > 4) ? $clog2(OVS) : 2;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVS - 1);
  localparam logic [TCW-1:0] TICK_HALF = TCW'(OVS / 2 - 1);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  // Line synchronizer plus one history flop for the 1->0 start detector.
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic start_edge;

  // FSM and datapath registers, with their next-state values.
  uart_state_t          state_q, state_n;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_n;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 brk_q, brk_n;
  logic                 keep_byte;

  // Tick generator handshake and output-stage controls.
  logic                 tick;
  logic                 tick_clear;
  logic                 load;
  logic                 frame_err_n;
  logic                 overrun_n;

  // Registered outputs.
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

`ifdef UART_RX_PARITY_EN
  logic                 discard_q, discard_n;
  logic                 parity_err_n;
  logic                 parity_err_q;
`endif

  uart_rx_tick #(
    .BR   (BR),
    .CLKF (CLKF),
    .OVS  (OVS)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Two-flop synchronizer; reset to the idle level so leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;

  // A byte that failed its parity check is still framed, but never delivered.
`ifdef UART_RX_PARITY_EN
  assign keep_byte = ~discard_q;
`else
  assign keep_byte = 1'b1;
`endif

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      brk_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      discard_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      tick_cnt_q <= tick_cnt_n;
      bit_cnt_q  <= bit_cnt_n;
      shift_q    <= shift_n;
      brk_q      <= brk_n;
`ifdef UART_RX_PARITY_EN
      discard_q  <= discard_n;
`endif
    end
  end

  // Next-state logic. tick_cnt counts oversampling ticks inside the current
  // bit: the start bit is checked half a bit in, later bits one full bit
  // after that, so every sample lands near the middle of its bit.
  always_comb begin
    state_n     = state_q;
    tick_cnt_n  = tick_cnt_q;
    bit_cnt_n   = bit_cnt_q;
    shift_n     = shift_q;
    brk_n       = brk_q;
    tick_clear  = 1'b0;
    load        = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    discard_n    = discard_q;
    parity_err_n = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef UART_RX_PARITY_EN
        discard_n = 1'b0;
`endif
        if (start_edge) begin
          state_n    = ST_START;
          tick_clear = 1'b1;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end

      // A line that is high again at mid start bit was a glitch.
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_n = '0;
            state_n    = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_n = tick_cnt_q + 1'b1;
          end
        end
      end

      // LSB arrives first, so shift in from the top.
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            shift_n    = {rx_sync, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n   = ST_PARITY;
`else
              state_n   = ST_STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // On mismatch the stop bit is still consumed so framing stays intact.
      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            state_n    = ST_STOP;
            if (rx_sync != even_parity(shift_q)) begin
              parity_err_n = 1'b1;
              discard_n    = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt_q + 1'b1;
          end
        end
      end
`endif

      // After a low stop bit, stay here until the line returns high so a
      // held break cannot be mistaken for a new start bit.
      ST_STOP: begin
        if (brk_q) begin
          if (rx_sync) begin
            brk_n   = 1'b0;
            state_n = ST_IDLE;
          end
        end else if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_n = '0;
            if (!rx_sync) begin
              frame_err_n = 1'b1;
              brk_n       = 1'b1;
            end else begin
              state_n = ST_IDLE;
              if (keep_byte) begin
                if (valid_q) begin
                  overrun_n = 1'b1;
                end else begin
                  load = 1'b1;
                end
              end
            end
          end else begin
            tick_cnt_n = tick_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Output stage: a new load wins over a same-cycle accept; data only
  // changes on a load, and a load only happens while valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
      frame_err_q <= frame_err_n;
      overrun_q   <= overrun_n;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_n;
`endif
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif

endmodule
